// File: rtl/riscv_csr_ctrl.sv
// riscv_csr_ctrl
// Initiator side of the CSR register file. Takes one CSR or trap request
// from execute, performs the read-modify-write on the generic channel or the
// dedicated mstatus/mepc/mcause channels, then returns the old CSR value or
// a PC redirect. Sequence: IDLE -> READ -> WRITE -> RESP -> IDLE.

module riscv_csr_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int CSR_ADDR_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] MSTATUS_RESET = DATA_WIDTH'('h1800)
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [2:0]                req_op_i,
   input  logic [CSR_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0]     req_src_i,
   input  logic                      req_src_zero_i,
   input  logic [DATA_WIDTH-1:0]     req_pc_i,

   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [DATA_WIDTH-1:0]     resp_rd_data_o,
   output logic                      resp_redirect_o,
   output logic [DATA_WIDTH-1:0]     resp_redirect_pc_o,
   output logic                      resp_illegal_o,

   output logic [CSR_ADDR_WIDTH-1:0] csr_read_addr_o,
   input  logic [DATA_WIDTH-1:0]     csr_read_data_i,
   output logic [CSR_ADDR_WIDTH-1:0] csr_write_addr_o,
   output logic [DATA_WIDTH-1:0]     csr_write_data_o,
   output logic                      csr_write_valid_o,

   output logic [DATA_WIDTH-1:0]     csr_mstatus_write_data_o,
   output logic [DATA_WIDTH-1:0]     csr_mepc_write_data_o,
   output logic [DATA_WIDTH-1:0]     csr_mcause_write_data_o,
   output logic                      csr_mstatus_write_valid_o,
   output logic                      csr_mepc_write_valid_o,
   output logic                      csr_mcause_write_valid_o,

   input  logic [DATA_WIDTH-1:0]     csr_mstatus_read_data_i,
   input  logic [DATA_WIDTH-1:0]     csr_mepc_read_data_i,
   input  logic [DATA_WIDTH-1:0]     csr_mtvec_read_data_i
);

   localparam logic [2:0] OP_CSRRW = 3'd1;
   localparam logic [2:0] OP_CSRRS = 3'd2;
   localparam logic [2:0] OP_CSRRC = 3'd3;
   localparam logic [2:0] OP_ECALL = 3'd4;
   localparam logic [2:0] OP_MRET  = 3'd5;

   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'('h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC   = CSR_ADDR_WIDTH'('h305);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'('h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'('h342);

   localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL_M = DATA_WIDTH'(11);

   // Machine-mode privilege code recorded into MPP on trap entry, taken from
   // the MPP field of the mstatus reset image.
   localparam logic [1:0] TRAP_MPP = MSTATUS_RESET[12:11];

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_t;

   state_t state;
   state_t state_next;

   logic [2:0]                op_q;
   logic [CSR_ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]     src_q;
   logic                      src_zero_q;
   logic [DATA_WIDTH-1:0]     pc_q;
   logic [DATA_WIDTH-1:0]     old_q;
   logic [DATA_WIDTH-1:0]     target_q;

   logic                      is_csr_op;
   logic                      is_ecall;
   logic                      is_mret;
   logic                      addr_supported;
   logic                      illegal;

   logic [DATA_WIDTH-1:0]     csr_new_value;
   logic                      csr_write_en;
   logic [DATA_WIDTH-1:0]     ecall_mstatus;
   logic [DATA_WIDTH-1:0]     mret_mstatus;

   // Classify the latched request: op kind, address support, legality.
   always_comb begin
      is_csr_op      = (op_q == OP_CSRRW) || (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
      is_ecall       = (op_q == OP_ECALL);
      is_mret        = (op_q == OP_MRET);
      addr_supported = (addr_q == ADDR_MSTATUS) || (addr_q == ADDR_MTVEC) ||
                       (addr_q == ADDR_MEPC)    || (addr_q == ADDR_MCAUSE);
      illegal        = !(is_csr_op || is_ecall || is_mret) || (is_csr_op && !addr_supported);
   end

   // New value for the generic channel; set/clear with a zero source leave
   // the CSR untouched, so they issue no write at all.
   always_comb begin
      csr_new_value = '0;
      csr_write_en  = 1'b0;
      case (op_q)
         OP_CSRRW: begin
            csr_new_value = src_q;
            csr_write_en  = 1'b1;
         end
         OP_CSRRS: begin
            csr_new_value = old_q | src_q;
            csr_write_en  = !src_zero_q;
         end
         OP_CSRRC: begin
            csr_new_value = old_q & ~src_q;
            csr_write_en  = !src_zero_q;
         end
         default: begin
            csr_new_value = '0;
            csr_write_en  = 1'b0;
         end
      endcase
      if (illegal) begin
         csr_write_en = 1'b0;
      end
   end

   // mstatus images for trap entry (stack MIE into MPIE, disable, record
   // MPP) and trap return (restore MIE, set MPIE, drop MPP to user).
   always_comb begin
      ecall_mstatus        = old_q;
      ecall_mstatus[7]     = old_q[3];
      ecall_mstatus[3]     = 1'b0;
      ecall_mstatus[12:11] = TRAP_MPP;

      mret_mstatus         = old_q;
      mret_mstatus[3]      = old_q[7];
      mret_mstatus[7]      = 1'b1;
      mret_mstatus[12:11]  = 2'b00;
   end

   // State register; reset abandons any in-flight request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: fixed READ/WRITE steps, RESP waits for the consumer.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid_i) state_next = READ;
         READ:    state_next = WRITE;
         WRITE:   state_next = RESP;
         RESP:    if (resp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture in IDLE, and old value / redirect target capture in
   // READ (mtvec and mepc are sampled before the trap writes land).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         addr_q     <= '0;
         src_q      <= '0;
         src_zero_q <= 1'b0;
         pc_q       <= '0;
         old_q      <= '0;
         target_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  op_q       <= req_op_i;
                  addr_q     <= req_addr_i;
                  src_q      <= req_src_i;
                  src_zero_q <= req_src_zero_i;
                  pc_q       <= req_pc_i;
               end
            end
            READ: begin
               if (illegal) begin
                  old_q <= '0;
               end else if (is_csr_op) begin
                  old_q <= csr_read_data_i;
               end else begin
                  old_q <= csr_mstatus_read_data_i;
               end
               if (is_ecall) begin
                  target_q <= csr_mtvec_read_data_i & ~DATA_WIDTH'(3);
               end else if (is_mret) begin
                  target_q <= csr_mepc_read_data_i;
               end else begin
                  target_q <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs: read address only in READ, strobes only in WRITE, response
   // fields only in RESP; everything else idles at zero.
   always_comb begin
      req_ready_o               = (state == IDLE);
      csr_read_addr_o           = '0;
      csr_write_addr_o          = '0;
      csr_write_data_o          = '0;
      csr_write_valid_o         = 1'b0;
      csr_mstatus_write_data_o  = '0;
      csr_mepc_write_data_o     = '0;
      csr_mcause_write_data_o   = '0;
      csr_mstatus_write_valid_o = 1'b0;
      csr_mepc_write_valid_o    = 1'b0;
      csr_mcause_write_valid_o  = 1'b0;
      resp_valid_o              = 1'b0;
      resp_rd_data_o            = '0;
      resp_redirect_o           = 1'b0;
      resp_redirect_pc_o        = '0;
      resp_illegal_o            = 1'b0;

      case (state)
         READ: begin
            csr_read_addr_o = addr_q;
         end
         WRITE: begin
            if (is_csr_op && csr_write_en) begin
               csr_write_valid_o = 1'b1;
               csr_write_addr_o  = addr_q;
               csr_write_data_o  = csr_new_value;
            end else if (is_ecall) begin
               csr_mstatus_write_valid_o = 1'b1;
               csr_mstatus_write_data_o  = ecall_mstatus;
               csr_mepc_write_valid_o    = 1'b1;
               csr_mepc_write_data_o     = pc_q;
               csr_mcause_write_valid_o  = 1'b1;
               csr_mcause_write_data_o   = CAUSE_ECALL_M;
            end else if (is_mret) begin
               csr_mstatus_write_valid_o = 1'b1;
               csr_mstatus_write_data_o  = mret_mstatus;
            end
         end
         RESP: begin
            resp_valid_o       = 1'b1;
            resp_rd_data_o     = is_csr_op ? old_q : '0;
            resp_redirect_o    = is_ecall || is_mret;
            resp_redirect_pc_o = target_q;
            resp_illegal_o     = illegal;
         end
         default: begin
         end
      endcase
   end

endmodule
